// File: rtl/rf_writeback_queue.sv
// rtl/rf_writeback_queue.sv - in-order writeback queue in front of the 4 x 16-bit register file
//
// Buffers register writeback requests and drains at most one per cycle onto
// the register file's synchronous write port. Still-queued data is bypassed
// onto both asynchronous read paths so readers always see the newest value.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   in_valid/in_ready              request handshake
//   in_reg, in_data                request destination register and data
//   drain_en                       permits draining the head entry this cycle
//   rf_write, rf_write_register,
//   rf_write_data                  register file write port
//   rd_addr1, rd_addr2             read addresses (also wired to the register file)
//   rf_read_data1, rf_read_data2   register file read data
//   fwd_data1, fwd_data2           bypassed read data
//   count                          queued entries, 0..DEPTH
module rf_writeback_queue #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 2,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_reg,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 drain_en,
  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_write_register,
  output logic [WORD_SIZE-1:0] rf_write_data,
  input  logic [ADDR_W-1:0]    rd_addr1,
  input  logic [ADDR_W-1:0]    rd_addr2,
  input  logic [WORD_SIZE-1:0] rf_read_data1,
  input  logic [WORD_SIZE-1:0] rf_read_data2,
  output logic [WORD_SIZE-1:0] fwd_data1,
  output logic [WORD_SIZE-1:0] fwd_data2,
  output logic [ADDR_W:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]    reg_mem  [DEPTH];
  logic [WORD_SIZE-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt_q;

  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (cnt_q != '0);

  // Ready is masked by reset so nothing is accepted while the queue is held clear.
  assign in_ready = (cnt_q != FULL_CNT) & ~reset;
  assign rf_write = not_empty & drain_en;

  assign push = in_valid & in_ready;
  assign pop  = rf_write;

  assign rf_write_register = not_empty ? reg_mem[rd_ptr]  : '0;
  assign rf_write_data     = not_empty ? data_mem[rd_ptr] : '0;

  assign count = (ADDR_W+1)'(cnt_q);

  // Entry contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= in_reg;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Walk the live entries from oldest (age 0 = head) to youngest; a later
  // match overrides an earlier one, so the youngest matching entry wins.
  // The head counts as queued even while it is being written this cycle.
  always_comb begin
    fwd_data1 = rf_read_data1;
    fwd_data2 = rf_read_data2;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < cnt_q) begin
        if (reg_mem[rd_ptr + PTR_W'(i)] == rd_addr1)
          fwd_data1 = data_mem[rd_ptr + PTR_W'(i)];
        if (reg_mem[rd_ptr + PTR_W'(i)] == rd_addr2)
          fwd_data2 = data_mem[rd_ptr + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb/tb_rf_writeback_queue.sv - self-checking bench for rf_writeback_queue
module tb_rf_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_reg;
  logic [15:0] in_data;
  logic        drain_en;
  logic        rf_write;
  logic [1:0]  rf_write_register;
  logic [15:0] rf_write_data;
  logic [1:0]  rd_addr1;
  logic [1:0]  rd_addr2;
  logic [15:0] rf_read_data1;
  logic [15:0] rf_read_data2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  rf_writeback_queue #(.WORD_SIZE(16), .ADDR_W(2), .DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_reg            (in_reg),
    .in_data           (in_data),
    .drain_en          (drain_en),
    .rf_write          (rf_write),
    .rf_write_register (rf_write_register),
    .rf_write_data     (rf_write_data),
    .rd_addr1          (rd_addr1),
    .rd_addr2          (rd_addr2),
    .rf_read_data1     (rf_read_data1),
    .rf_read_data2     (rf_read_data2),
    .fwd_data1         (fwd_data1),
    .fwd_data2         (fwd_data2),
    .count             (count)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents as a plain list, oldest first.
  typedef struct {
    logic [1:0]  r;
    logic [15:0] d;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic        iv;
    logic [1:0]  ir;
    logic [15:0] id;
    logic        de;
    logic [1:0]  a1;
    logic [1:0]  a2;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        e_ready;
    logic        e_wr;
    logic [1:0]  e_wreg;
    logic [15:0] e_wdata;
    logic [15:0] e_f1;
    logic [15:0] e_f2;
    logic [2:0]  e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic iv, input logic [1:0] ir, input logic [15:0] id,
                         input logic de, input logic [1:0] a1, input logic [1:0] a2,
                         input logic [15:0] r1, input logic [15:0] r2,
                         input logic e_ready, input logic e_wr, input logic [1:0] e_wreg,
                         input logic [15:0] e_wdata, input logic [15:0] e_f1,
                         input logic [15:0] e_f2, input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.ir = ir; v.id = id; v.de = de; v.a1 = a1; v.a2 = a2;
    v.r1 = r1; v.r2 = r2; v.e_ready = e_ready; v.e_wr = e_wr; v.e_wreg = e_wreg;
    v.e_wdata = e_wdata; v.e_f1 = e_f1; v.e_f2 = e_f2; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  // One clock cycle: drive just after the rising edge, compare against the
  // model at the falling edge, then advance the model across the next edge.
  task automatic step(input logic iv, input logic [1:0] ir, input logic [15:0] id,
                      input logic de, input logic [1:0] a1, input logic [1:0] a2,
                      input logic [15:0] r1, input logic [15:0] r2, input logic rst);
    int          n;
    logic        e_ready;
    logic        e_wr;
    logic [1:0]  e_wreg;
    logic [15:0] e_wdata;
    logic [15:0] f1;
    logic [15:0] f2;
    @(posedge clk);
    #1;
    reset = rst; in_valid = iv; in_reg = ir; in_data = id; drain_en = de;
    rd_addr1 = a1; rd_addr2 = a2; rf_read_data1 = r1; rf_read_data2 = r2;
    if (rst) mq.delete();
    @(negedge clk);
    n       = mq.size();
    e_ready = !rst && (n != 4);
    e_wr    = (n != 0) && de;
    e_wreg  = (n != 0) ? mq[0].r : 2'd0;
    e_wdata = (n != 0) ? mq[0].d : 16'd0;
    f1 = r1;
    f2 = r2;
    for (int i = 0; i < n; i++) begin
      if (mq[i].r == a1) f1 = mq[i].d;
      if (mq[i].r == a2) f2 = mq[i].d;
    end
    chk("m_in_ready", in_ready, e_ready);
    chk("m_rf_write", rf_write, e_wr);
    chk("m_wreg", rf_write_register, e_wreg);
    chk("m_wdata", rf_write_data, e_wdata);
    chk("m_fwd1", fwd_data1, f1);
    chk("m_fwd2", fwd_data2, f2);
    chk("m_count", count, n);
    if (!rst) begin
      if (e_wr) void'(mq.pop_front());
      if (iv && e_ready) begin
        ent_t e;
        e.r = ir;
        e.d = id;
        mq.push_back(e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; drain_en = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; rf_read_data1 = '0; rf_read_data2 = '0;

    // Directed vectors: single-entry latency, fill to full, refused push,
    // youngest-match forwarding, in-order drain.
    add_vec(1, 1, 16'h1234, 1, 1, 2, 16'h1111, 16'h2222, 1, 0, 0, 16'h0000, 16'h1111, 16'h2222, 0);
    add_vec(0, 0, 16'h0000, 1, 1, 2, 16'h1111, 16'h2222, 1, 1, 1, 16'h1234, 16'h1234, 16'h2222, 1);
    add_vec(0, 0, 16'h0000, 1, 1, 2, 16'h1111, 16'h2222, 1, 0, 0, 16'h0000, 16'h1111, 16'h2222, 0);
    add_vec(1, 2, 16'hAAAA, 0, 2, 1, 16'h1111, 16'h5555, 1, 0, 0, 16'h0000, 16'h1111, 16'h5555, 0);
    add_vec(1, 2, 16'hBBBB, 0, 2, 1, 16'h1111, 16'h5555, 1, 0, 2, 16'hAAAA, 16'hAAAA, 16'h5555, 1);
    add_vec(1, 3, 16'h0001, 0, 2, 1, 16'h1111, 16'h5555, 1, 0, 2, 16'hAAAA, 16'hBBBB, 16'h5555, 2);
    add_vec(1, 0, 16'hFFFF, 0, 2, 1, 16'h1111, 16'h5555, 1, 0, 2, 16'hAAAA, 16'hBBBB, 16'h5555, 3);
    add_vec(1, 1, 16'h9999, 0, 2, 1, 16'h1111, 16'h5555, 0, 0, 2, 16'hAAAA, 16'hBBBB, 16'h5555, 4);
    add_vec(0, 0, 16'h0000, 0, 2, 1, 16'h1111, 16'h5555, 0, 0, 2, 16'hAAAA, 16'hBBBB, 16'h5555, 4);
    add_vec(0, 0, 16'h0000, 1, 2, 1, 16'h1111, 16'h5555, 0, 1, 2, 16'hAAAA, 16'hBBBB, 16'h5555, 4);
    add_vec(0, 0, 16'h0000, 1, 2, 1, 16'h1111, 16'h5555, 1, 1, 2, 16'hBBBB, 16'hBBBB, 16'h5555, 3);
    add_vec(0, 0, 16'h0000, 1, 2, 1, 16'h1111, 16'h5555, 1, 1, 3, 16'h0001, 16'h1111, 16'h5555, 2);
    add_vec(0, 0, 16'h0000, 1, 2, 1, 16'h1111, 16'h5555, 1, 1, 0, 16'hFFFF, 16'h1111, 16'h5555, 1);
    add_vec(0, 0, 16'h0000, 1, 2, 1, 16'h1111, 16'h5555, 1, 0, 0, 16'h0000, 16'h1111, 16'h5555, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rf_write", rf_write, 0);
    chk("rst_count", count, 0);

    foreach (tbl[k]) begin
      step(tbl[k].iv, tbl[k].ir, tbl[k].id, tbl[k].de, tbl[k].a1, tbl[k].a2,
           tbl[k].r1, tbl[k].r2, 1'b0);
      chk($sformatf("v%0d_in_ready", k), in_ready, tbl[k].e_ready);
      chk($sformatf("v%0d_rf_write", k), rf_write, tbl[k].e_wr);
      chk($sformatf("v%0d_wreg", k), rf_write_register, tbl[k].e_wreg);
      chk($sformatf("v%0d_wdata", k), rf_write_data, tbl[k].e_wdata);
      chk($sformatf("v%0d_fwd1", k), fwd_data1, tbl[k].e_f1);
      chk($sformatf("v%0d_fwd2", k), fwd_data2, tbl[k].e_f2);
      chk($sformatf("v%0d_count", k), count, tbl[k].e_cnt);
    end

    // Steady state: one entry queued, push and pop every cycle.
    step(1, 1, 16'h0100, 0, 0, 0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1, 2'(k), 16'h0200 + 16'(k), 1, 0, 0, 16'h0, 16'h0, 1'b0);
      chk("ss_count", count, 1);
      chk("ss_rf_write", rf_write, 1);
      chk("ss_wdata", rf_write_data, (k == 0) ? 16'h0100 : 16'h0200 + 16'(k - 1));
    end
    step(0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0, 1'b0);
    step(0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1'b0);

    // Reset arriving mid-drain with three entries still queued.
    for (int k = 0; k < 4; k++)
      step(1, 2'(k), 16'hC000 + 16'(k), 0, 0, 1, 16'h0, 16'h0, 1'b0);
    step(0, 0, 16'h0, 1, 0, 1, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("md_count3", count, 3);
    chk("md_rf_write_before", rf_write, 1);
    #2;
    reset = 1'b1;
    mq.delete();
    #1;
    chk("md_rf_write_async", rf_write, 0);
    chk("md_count_async", count, 0);
    chk("md_in_ready_async", in_ready, 0);
    step(0, 0, 16'h0, 1, 0, 1, 16'h0, 16'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 16'h0, 1, 2'(k), 1, 16'h7777, 16'h8888, 1'b0);
      chk("md_no_stale_write", rf_write, 0);
      chk("md_in_ready_after", in_ready, 1);
    end

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 16'($urandom),
           ($urandom_range(0, 9) < 5), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom), ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
